// File: rtl/seg_pkg.sv
// Shared constants and the hex-to-segment glyph lookup used by the display driver.
// Segments are active-low, ordered a..g on bits 7..1 with the decimal point on bit 0.
package seg_pkg;

    typedef logic [7:0] seg_t;

    localparam seg_t SEG_BLANK = 8'hFF;

    localparam seg_t GLYPHS [16] = '{
        8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
        8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71
    };

    function automatic seg_t hex2seg(input logic [3:0] nibble);
        return GLYPHS[nibble];
    endfunction

endpackage

// File: rtl/seg_scan_if.sv
// Load/mask inputs and display outputs of the multi-digit driver, bundled as one bus.
interface seg_scan_if #(
    parameter int DIGITS = 8
);

    logic                  load;
    logic [4*DIGITS-1:0]   value;
    logic [DIGITS-1:0]     blank_mask;
    logic [DIGITS-1:0]     dp_mask;
    logic [DIGITS-1:0]     blink_mask;
    logic                  lz_en;
    logic [8*DIGITS-1:0]   seg_par;
    logic [7:0]            seg_mux;
    logic [DIGITS-1:0]     an_n;
    logic                  frame;

    modport master (
        output load, value, blank_mask, dp_mask, blink_mask, lz_en,
        input  seg_par, seg_mux, an_n, frame
    );

    modport slave (
        input  load, value, blank_mask, dp_mask, blink_mask, lz_en,
        output seg_par, seg_mux, an_n, frame
    );

endinterface

// File: rtl/seg_hex.sv
// Combinational single-digit decoder: 4-bit nibble to active-low seven-segment glyph.
module seg_hex
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output seg_t       seg
);

    assign seg = hex2seg(nibble);

endmodule

// File: rtl/seg_scan.sv
// Multi-digit hex display driver with frame-synchronous double buffering, masking,
// blinking, leading-zero suppression, and both static and scanned segment outputs.
module seg_scan #(
    parameter int DIGITS       = 8,
    parameter int SCAN_DIV     = 1000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    seg_scan_if.slave  bus
);

    import seg_pkg::*;

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [4*DIGITS-1:0] pend_value;
    logic [DIGITS-1:0]   pend_blank;
    logic [DIGITS-1:0]   pend_dp;
    logic [DIGITS-1:0]   pend_blink;
    logic                pend_lz;
    logic                pend;

    logic [4*DIGITS-1:0] act_value;
    logic [DIGITS-1:0]   act_blank;
    logic [DIGITS-1:0]   act_dp;
    logic [DIGITS-1:0]   act_blink;
    logic                act_lz;

    logic [DIV_W-1:0]    div;
    logic [IDX_W-1:0]    idx;
    logic [BLK_W-1:0]    blink_cnt;
    logic                blink_on;

    logic                div_wrap;
    logic                idx_last;
    logic                boundary;

    seg_t                glyph   [DIGITS];
    seg_t                pattern [DIGITS];
    logic [DIGITS-1:0]   lz_sup;
    logic                zero_run;

    assign div_wrap = (div == DIV_W'(SCAN_DIV - 1));
    assign idx_last = (idx == IDX_W'(DIGITS - 1));
    assign boundary = div_wrap && idx_last;

    // Slot divider, digit index and the frame-rate blink phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div       <= '0;
            idx       <= '0;
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else begin
            if (div_wrap) begin
                div <= '0;
                idx <= idx_last ? '0 : idx + 1'b1;
            end else begin
                div <= div + 1'b1;
            end
            if (boundary) begin
                if (blink_cnt == BLK_W'(BLINK_FRAMES - 1)) begin
                    blink_cnt <= '0;
                    blink_on  <= ~blink_on;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end
        end
    end

    // Double buffer: a load in the boundary cycle still commits the older pending
    // set now and keeps the new one pending for the following frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_value <= '0;
            pend_blank <= '0;
            pend_dp    <= '0;
            pend_blink <= '0;
            pend_lz    <= 1'b0;
            pend       <= 1'b0;
            act_value  <= '0;
            act_blank  <= '1;
            act_dp     <= '0;
            act_blink  <= '0;
            act_lz     <= 1'b0;
        end else begin
            if (boundary && pend) begin
                act_value <= pend_value;
                act_blank <= pend_blank;
                act_dp    <= pend_dp;
                act_blink <= pend_blink;
                act_lz    <= pend_lz;
            end
            if (bus.load) begin
                pend_value <= bus.value;
                pend_blank <= bus.blank_mask;
                pend_dp    <= bus.dp_mask;
                pend_blink <= bus.blink_mask;
                pend_lz    <= bus.lz_en;
                pend       <= 1'b1;
            end else if (boundary) begin
                pend <= 1'b0;
            end
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : gen_hex
        seg_hex u_hex (
            .nibble (act_value[4*g +: 4]),
            .seg    (glyph[g])
        );
    end

    // A zero run from the most significant digit downward marks suppressible digits.
    always_comb begin
        zero_run = 1'b1;
        lz_sup   = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run && (act_value[4*i +: 4] == 4'h0);
            if (i != 0) begin
                lz_sup[i] = act_lz && zero_run;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < DIGITS; i++) begin
            pattern[i] = SEG_BLANK;
            if (act_blank[i] || (act_blink[i] && !blink_on)) begin
                pattern[i] = SEG_BLANK;
            end else if (lz_sup[i]) begin
                pattern[i] = {7'h7F, ~act_dp[i]};
            end else begin
                pattern[i] = {glyph[i][7:1], glyph[i][0] & ~act_dp[i]};
            end
        end
    end

    // Mux segments and digit enable come from the same idx, so they stay aligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.seg_par <= '1;
            bus.seg_mux <= SEG_BLANK;
            bus.an_n    <= '1;
            bus.frame   <= 1'b0;
        end else begin
            for (int i = 0; i < DIGITS; i++) begin
                bus.seg_par[8*i +: 8] <= pattern[i];
            end
            bus.seg_mux <= pattern[idx];
            bus.an_n    <= ~(DIGITS'(1) << idx);
            bus.frame   <= boundary;
        end
    end

endmodule

// File: tb/tb_seg_scan.sv
// Directed bench for seg_scan with a queue of expected committed display words.
module tb_seg_scan;

    localparam int DIGITS       = 4;
    localparam int SCAN_DIV     = 4;
    localparam int BLINK_FRAMES = 2;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    int          cyc;
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_q [$];
    logic [31:0] shown = 32'hFFFF_FFFF;

    seg_scan_if #(.DIGITS(DIGITS)) bus ();

    seg_scan #(
        .DIGITS       (DIGITS),
        .SCAN_DIV     (SCAN_DIV),
        .BLINK_FRAMES (BLINK_FRAMES)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Counts active edges since reset release; drives the timing expectations.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
    endtask

    task automatic apply_load(input logic [15:0] v, input logic [3:0] b,
                              input logic [3:0] d, input logic [3:0] k, input logic lz);
        bus.load       = 1'b1;
        bus.value      = v;
        bus.blank_mask = b;
        bus.dp_mask    = d;
        bus.blink_mask = k;
        bus.lz_en      = lz;
        @(negedge clk);
        bus.load       = 1'b0;
    endtask

    task automatic wait_frame();
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            check("hold", bus.seg_par, shown);
            seen = (bus.frame === 1'b1);
        end
        check("frame_seen", 32'(bus.frame), 32'd1);
    endtask

    task automatic wait_commit();
        wait_frame();
        @(negedge clk);
        if (exp_q.size() > 0) shown = exp_q.pop_front();
        check("commit", bus.seg_par, shown);
    endtask

    initial begin
        logic [3:0] exp_an;
        int         hits;
        bit         on;

        bus.load       = 1'b0;
        bus.value      = '0;
        bus.blank_mask = '0;
        bus.dp_mask    = '0;
        bus.blink_mask = '0;
        bus.lz_en      = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_seg_par", bus.seg_par, 32'hFFFF_FFFF);
        check("rst_seg_mux", 32'(bus.seg_mux), 32'hFF);
        check("rst_an_n", 32'(bus.an_n), 32'hF);
        check("rst_frame", 32'(bus.frame), 32'd0);
        rst_n = 1'b1;

        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            exp_an = ~(4'b0001 << (((cyc - 1) / 4) % 4));
            check("idle_an_n", 32'(bus.an_n), 32'(exp_an));
            check("idle_seg_mux", 32'(bus.seg_mux), 32'hFF);
            check("idle_seg_par", bus.seg_par, 32'hFFFF_FFFF);
            check("idle_frame", 32'(bus.frame), (cyc % 16 == 0) ? 32'd1 : 32'd0);
        end
        @(negedge clk);

        apply_load(16'h12AF, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        exp_q.push_back(32'h9F25_1171);
        wait_commit();
        hits = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (bus.an_n === 4'b1110) begin
                hits++;
                check("mux_digit0", 32'(bus.seg_mux), 32'h71);
            end
        end
        check("mux_hits", 32'(hits), 32'd4);

        apply_load(16'h0050, 4'b0000, 4'b0000, 4'b0000, 1'b1);
        exp_q.push_back(32'hFFFF_4903);
        wait_commit();

        apply_load(16'h0000, 4'b0000, 4'b0000, 4'b0000, 1'b1);
        exp_q.push_back(32'hFFFF_FF03);
        wait_commit();

        apply_load(16'h1234, 4'b0000, 4'b0010, 4'b0000, 1'b0);
        exp_q.push_back(32'h9F25_0C99);
        wait_commit();

        apply_load(16'h1234, 4'b0010, 4'b0010, 4'b0000, 1'b0);
        exp_q.push_back(32'h9F25_FF99);
        wait_commit();

        apply_load(16'h1111, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        exp_q.push_back(32'h9F9F_9F9F);
        apply_load(16'h2222, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        exp_q[exp_q.size() - 1] = 32'h2525_2525;
        wait_commit();

        apply_load(16'h3333, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        exp_q.push_back(32'h0D0D_0D0D);
        for (int k = 0; k < 13; k++) begin
            @(negedge clk);
            check("hold_pre_boundary", bus.seg_par, shown);
        end
        apply_load(16'h4444, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        exp_q.push_back(32'h9999_9999);
        check("boundary_frame", 32'(bus.frame), 32'd1);
        @(negedge clk);
        shown = exp_q.pop_front();
        check("boundary_old_commit", bus.seg_par, shown);
        wait_commit();

        apply_load(16'h000F, 4'b0000, 4'b0000, 4'b0001, 1'b0);
        wait_frame();
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            on = ((((cyc - 1) / 16) / 2) % 2) == 0;
            check("blink", bus.seg_par, on ? 32'h0303_0371 : 32'h0303_03FF);
        end

        apply_load(16'h5555, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_seg_par", bus.seg_par, 32'hFFFF_FFFF);
        check("midrst_seg_mux", 32'(bus.seg_mux), 32'hFF);
        check("midrst_an_n", 32'(bus.an_n), 32'hF);
        check("midrst_frame", 32'(bus.frame), 32'd0);
        shown = 32'hFFFF_FFFF;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("first_enable", 32'(bus.an_n), 32'hE);
        wait_commit();

        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/seg_scan.md
# seg_scan

Multi-digit hex display driver that generalises the single-digit hex-to-seven-segment decoder to `DIGITS` digits. It double-buffers the display contents and commits new values only at frame boundaries, so the display never shows a torn value. It adds per-digit blanking, decimal points, blinking and leading-zero suppression. It drives both a static per-digit bus (for board-level segment arrays) and a time-multiplexed bus with active-low digit enables (for scanned displays).

## Interface
- `DIGITS`, 8: number of digits, legal range 1..16.
- `SCAN_DIV`, 1000: clk cycles per digit slot, minimum 2.
- `BLINK_FRAMES`, 64: frames per blink half-period, minimum 1.

- `clk`  in  1  sole clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `load`  in  1  single-cycle strobe; captures all value/mask inputs.
- `value`  in  4*DIGITS  hex nibbles; digit i = `value[4i+3:4i]`, digit 0 least significant.
- `blank_mask`  in  DIGITS  1 = digit dark.
- `dp_mask`  in  DIGITS  1 = decimal point lit.
- `blink_mask`  in  DIGITS  1 = digit blinks.
- `lz_en`  in  1  leading-zero suppression enable.
- `seg_par`  out  8*DIGITS  static segments, digit i = `seg_par[8i+7:8i]`.
- `seg_mux`  out  8  segments of the currently scanned digit.
- `an_n`  out  DIGITS  one-hot active-low digit enable.
- `frame`  out  1  one-cycle pulse at each frame boundary.

## Operation
- Segment encoding is active-low, ordered a..g,dp across bits 7..1,0. Hex glyphs: 0=03, 1=9F, 2=25, 3=0D, 4=99, 5=49, 6=41, 7=1F, 8=01, 9=09, A=11, b=C1, C=63, d=85, E=61, F=71. Blank = FF.
- Registers:
  - pending set: value plus three masks plus lz_en, together with a `pend` flag.
  - active set: same fields.
  - `div` counter, width clog2(SCAN_DIV).
  - `idx` digit index.
  - `blink_cnt` and `blink_on` phase.
- `load`=1: pending set <= inputs, `pend` <= 1. Repeated loads before a commit: the last one wins.
- Frame boundary = `div`==SCAN_DIV-1 and `idx`==DIGITS-1. At the boundary:
  - `frame` pulses.
  - If `pend`=1, active set <= pending set and `pend` <= 0.
  - `load` in the boundary cycle: the new data lands in pending, `pend` stays 1, and it is committed at the next boundary. The old pending contents are committed now.
- Scan: `div` counts 0..SCAN_DIV-1. On wrap, `idx` advances 0..DIGITS-1 and wraps to 0.
- Blink: `blink_cnt` counts frames 0..BLINK_FRAMES-1. On wrap, `blink_on` toggles.
- Per-digit pattern, evaluated from the active set in priority order:
  1. `blank_mask[i]`, or (`blink_mask[i]` and !`blink_on`) -> FF, and the dp is dark too.
  2. Else, suppressed leading zero -> FF with dp per `dp_mask`. A digit is a suppressed leading zero when `lz_en`, its nibble is 0, every higher digit's nibble is 0, and i≠0. Digit 0 is never suppressed.
  3. Else, glyph with bit0 cleared when `dp_mask[i]`.
- `seg_par` register <= all patterns each cycle.
- `seg_mux` register <= pattern[`idx`] each cycle.
- `an_n` register <= ~(1<<`idx`) each cycle.

## Timing
- Reset (async assert, sync-released by the system) forces:
  - pending and active value/masks to 0, with active `blank_mask` all ones.
  - `pend`=0, `div`=0, `idx`=0, `blink_cnt`=0, `blink_on`=1.
  - `seg_par` all FF, `seg_mux`=FF, `an_n` all ones, `frame`=0.
- Reset asserted mid-frame takes effect immediately. Pending data is lost.
- `seg_mux` and `an_n` are registered from the same `idx`, so they stay aligned. The first enable (`an_n`[0] low) appears one cycle after reset release.
- Load-to-display latency: 1 to DIGITS*SCAN_DIV cycles to the commit, plus 1 register stage.
- `frame` is combinational-free: it is registered and asserts in the cycle after the boundary edge.
- DIGITS=1: `an_n` is constantly 0 after the first cycle, and every slot wrap is a frame boundary.

## Structure
- Package `seg_pkg`:
  - `SEG_BLANK`=8'hFF.
  - 16-entry glyph constant table.
  - Function `hex2seg(nibble)`.
- Sub-module `seg_hex`: combinational 4-bit -> 8-bit active-low decoder wrapping `hex2seg`, instantiated DIGITS times.
- Scan/blink counters, buffers and masking stay in `seg_scan`.

## Test plan
Benches use DIGITS=4, SCAN_DIV=4, BLINK_FRAMES=2.
- Reset then idle:
  - `seg_par`=FFFFFFFF and `seg_mux`=FF throughout.
  - `an_n` cycles 1110,1101,1011,0111, each held 4 cycles.
  - `frame` pulses every 16 cycles.
- Load `value`=16'h12AF, masks 0:
  - Before the next boundary, `seg_par` still all FF.
  - After it, `seg_par`=9F_25_11_71.
  - `seg_mux` equals 71 while `an_n`=1110.
- `lz_en`=1:
  - `value`=16'h0050 -> FF_FF_49_03.
  - `value`=0 -> FF_FF_FF_03.
- `dp_mask`=0010 with `value`=16'h1234 -> 9F_25_0C_99. Adding `blank_mask`=0010 -> 9F_25_FF_99.
- Two loads in one frame (h1111 then h2222) -> only 25_25_25_25 appears. A load on the boundary cycle appears one frame later.
- `blink_mask`=0001 with `value`=h000F:
  - digit 0 alternates 71/FF every 2 frames.
  - Asserting `rst_n`=0 mid-frame forces all FF and `an_n`=1111 in the same cycle.
